// File: rtl/fpacc_ctrl.sv
// Streaming IEEE-754 packet accumulator that drives an external multi-cycle fpadd core
// through a start/done handshake and returns the sum and element count per packet.
module fpacc_ctrl #(
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               add_start,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_sum,
    input  logic               add_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        acc_r, acc_s;
    logic [31:0]        op_r, op_s;
    logic               last_r, last_s;
    logic [COUNT_W-1:0] count_r, count_s;
    logic               err_r, err_s;
    logic [TMR_W-1:0]   tmr_r, tmr_s;
    logic               in_ready_r, add_start_r, out_valid_r;

    // Signed zeros are treated alike; the adder cannot take either as an operand.
    function automatic logic is_zero(input logic [31:0] x);
        is_zero = (x[30:0] == 31'h0);
    endfunction

    // Next-state and datapath update for the accept/issue/wait/output sequence.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        op_s    = op_r;
        last_s  = last_r;
        count_s = count_r;
        err_s   = err_r;
        tmr_s   = tmr_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    op_s   = in_data;
                    last_s = in_last;
                    if (count_r != COUNT_MAX) begin
                        count_s = count_r + COUNT_ONE;
                    end else begin
                        count_s = count_r;
                    end
                    if (is_zero(acc_r)) begin
                        acc_s   = in_data;
                        state_s = in_last ? OUT : IDLE;
                    end else if (is_zero(in_data)) begin
                        state_s = in_last ? OUT : IDLE;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                tmr_s   = {TMR_W{1'b0}};
                state_s = WAIT;
            end
            WAIT: begin
                if (add_done) begin
                    acc_s   = add_sum;
                    state_s = last_r ? OUT : IDLE;
                end else if (tmr_r == TMR_LAST) begin
                    // Timed-out element stays counted but contributes nothing to the sum.
                    err_s   = 1'b1;
                    state_s = last_r ? OUT : IDLE;
                end else begin
                    tmr_s   = tmr_r + TMR_ONE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_s   = 32'h0;
                    count_s = {COUNT_W{1'b0}};
                    err_s   = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            acc_r       <= 32'h0;
            op_r        <= 32'h0;
            last_r      <= 1'b0;
            count_r     <= {COUNT_W{1'b0}};
            err_r       <= 1'b0;
            tmr_r       <= {TMR_W{1'b0}};
            in_ready_r  <= 1'b1;
            add_start_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            op_r        <= op_s;
            last_r      <= last_s;
            count_r     <= count_s;
            err_r       <= err_s;
            tmr_r       <= tmr_s;
            in_ready_r  <= (state_s == IDLE);
            add_start_r <= (state_s == ISSUE);
            out_valid_r <= (state_s == OUT);
        end
    end

    assign in_ready  = in_ready_r;
    assign add_start = add_start_r;
    assign add_a     = acc_r;
    assign add_b     = op_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;
    assign out_count = count_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_fpacc_ctrl.sv
// Directed bench for fpacc_ctrl with a behavioural fixed-latency adder that returns
// hand-computed sums for the operand pairs the vectors use.
module tb_fpacc_ctrl;

    localparam int COUNT_W = 16;
    localparam int TIMEOUT = 512;
    localparam int LAT     = 4;
    localparam int BOUND   = 2000;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, in_ready, in_last;
    logic [31:0]        in_data;
    logic               add_start, add_done;
    logic [31:0]        add_a, add_b, add_sum;
    logic               out_valid, out_ready, out_err;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] out_count;

    int tests_run = 0;
    int tests_failed = 0;
    int start_total = 0;
    int wait_total = 0;
    logic no_done = 1'b0;
    logic ab_unstable = 1'b0;
    int cnt = 0;
    logic [31:0] ma, mb;

    fpacc_ctrl #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Hand-computed single-precision sums for the pairs the vectors produce.
    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: fsum = 32'h40400000;
            {32'h40400000, 32'h40400000}: fsum = 32'h40C00000;
            {32'h40000000, 32'h40000000}: fsum = 32'h40800000;
            default:                      fsum = 32'h7FC00000;
        endcase
    endfunction

    // Adder model: done pulse LAT cycles after start unless no_done is set.
    always @(posedge clk) begin
        if (reset) begin
            cnt      <= 0;
            add_done <= 1'b0;
            add_sum  <= 32'h0;
        end else begin
            add_done <= 1'b0;
            if (add_start) begin
                ma  <= add_a;
                mb  <= add_b;
                cnt <= LAT;
            end else if (cnt != 0) begin
                if (add_a != ma || add_b != mb) ab_unstable <= 1'b1;
                cnt <= cnt - 1;
                if (cnt == 1 && !no_done) begin
                    add_done <= 1'b1;
                    add_sum  <= fsum(ma, mb);
                end
            end
        end
    end

    // Event counters: start pulses, and cycles spent waiting on the adder.
    always @(posedge clk) begin
        if (add_start) start_total <= start_total + 1;
        if (!reset && !in_ready && !out_valid && !add_start) wait_total <= wait_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("send_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] d, input int c, input logic e);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check({tag, "_outvalid_timeout"}, 32'(n), 32'(0));
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_err"}, 32'(out_err), 32'(e));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {30'h0, in_ready, out_valid}, 32'h2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        check({tag, "_add_start"}, 32'(add_start), 32'h0);
        check({tag, "_add_a"}, add_a, 32'h0);
        check({tag, "_add_b"}, add_b, 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_count"}, 32'(out_count), 32'h0);
        check({tag, "_out_err"}, 32'(out_err), 32'h0);
    endtask

    initial begin
        int s0, w0;
        logic [31:0] hold_d;
        reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_outputs("rst");

        // 1 + 2 + 3 = 6 with two adder transactions
        s0 = start_total;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        take("sum3", 32'h40C00000, 3, 1'b0);
        check("sum3_starts", 32'(start_total - s0), 32'd2);

        // single word: pure bypass, result one cycle after accept
        s0 = start_total;
        send(32'h40490FDB, 1'b1);
        check("single_latency", 32'(out_valid), 32'h1);
        take("single", 32'h40490FDB, 1, 1'b0);
        check("single_starts", 32'(start_total - s0), 32'd0);

        // zero bypass, both positive and negative zero
        s0 = start_total;
        send(32'h00000000, 1'b0);
        send(32'h3F800000, 1'b1);
        take("zero_a", 32'h3F800000, 2, 1'b0);
        send(32'hBF800000, 1'b0);
        send(32'h80000000, 1'b1);
        take("zero_b", 32'hBF800000, 2, 1'b0);
        check("zero_starts", 32'(start_total - s0), 32'd0);

        // output back-pressure for 5 cycles with a word offered meanwhile
        send(32'h3F800000, 1'b1);
        hold_d = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h40000000;
            in_last  = 1'b1;
            check("stall_valid", {29'h0, out_valid, in_ready, out_err}, 32'h4);
            check("stall_data", out_data, hold_d);
            check("stall_count", 32'(out_count), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take("stall", 32'h3F800000, 1, 1'b0);
        send(32'h40000000, 1'b1);
        take("after_stall", 32'h40000000, 1, 1'b0);

        // adder never completes: element dropped, error flagged
        no_done = 1'b1;
        w0 = wait_total;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        take("tmo", 32'h3F800000, 2, 1'b1);
        check("tmo_wait_cycles", 32'(wait_total - w0), 32'(TIMEOUT));
        no_done = 1'b0;
        send(32'h3F800000, 1'b1);
        take("post_tmo", 32'h3F800000, 1, 1'b0);

        // reset while waiting on the adder
        no_done = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        repeat (5) @(negedge clk);
        check("pre_rst_waiting", {30'h0, in_ready, out_valid}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        no_done = 1'b0;
        check_reset_outputs("rst_wait");
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        take("post_rst", 32'h40800000, 2, 1'b0);

        check("ab_stable", 32'(ab_unstable), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fpacc_ctrl.md
# fpacc_ctrl

Streaming single-precision accumulator controller that acts as the initiator for the team's multi-cycle `fpadd` core. It accepts a packet of IEEE-754 words on a valid/ready input, issues one `start`/`done` transaction per non-trivial addition, and presents the packet sum and element count on a valid/ready output. It sits between a data source and an `fpadd` instance; the adder is external and shares clk/reset.

## Interface

- COUNT_W, 16: width of element counter.
- TIMEOUT, 512: max cycles waited for add_done per transaction; exceeds adder worst case of 255 align + 24 normalise + overhead.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  32  IEEE-754 operand.
- in_last  in  1  final word of packet.
- add_start  out  1  one-cycle start pulse to adder.
- add_a  out  32  adder operand a (accumulator).
- add_b  out  32  adder operand b (captured input).
- add_sum  in  32  adder result.
- add_done  in  1  adder result valid.
- out_valid  out  1  packet result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  accumulated sum.
- out_count  out  COUNT_W  words accepted in packet, saturating.
- out_err  out  1  at least one adder timeout in packet.

## Operation

- Registers: acc[31:0], op[31:0], last_r, count, err, tmr. Zero test: z(x) = (x[30:0]==0).
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: in_ready=1. On in_valid: op<=in_data, last_r<=in_last, count<=count+1 (saturate at all-ones). Then:
  - z(acc) true: acc<=in_data, no adder transaction; go OUT if in_last, else stay IDLE.
  - z(in_data) true: acc unchanged; same next state.
  - otherwise go ISSUE.
- Zero bypass is mandatory: the adder does not recognise zero operands.
- ISSUE: add_start=1 for exactly this cycle; add_a=acc, add_b=op held stable from ISSUE through WAIT; tmr<=0; go WAIT.
- WAIT: add_done ignored in ISSUE cycle; first sampled in cycle after ISSUE.
  - add_done=1: acc<=add_sum; go OUT if last_r, else IDLE.
  - Else tmr++. On tmr==TIMEOUT-1 without done: err<=1, acc unchanged, element dropped from sum but still counted; go OUT if last_r, else IDLE.
- OUT: out_valid=1, out_data=acc, out_count=count, out_err=err, all stable until handshake. On out_ready: acc<=0, count<=0, err<=0, go IDLE.
- add_start=0 in every state except ISSUE. No NaN/Inf special handling; adder propagates.

## Timing

- Reset values: state IDLE, in_ready=1 (first cycle after reset), add_start=0, add_a=0, add_b=0, out_valid=0, out_data=0, out_count=0, out_err=0, acc=0.
- Reset in any state, including WAIT, aborts. Adder is reset by the same signal, and no stale add_done is sampled.
- Throughput: bypassed word 1 cycle; added word 1 (accept) + 1 (ISSUE) + adder latency + 1.
- Result latency: last word accepted to out_valid = 1 cycle (bypass) or done+1 cycle.
- in_ready=0 in ISSUE, WAIT, OUT. No new packet is accepted while a result is pending.
- Same-cycle out_valid&out_ready: IDLE next cycle; in_ready is not combinationally tied to out_ready.

## Test plan

- 0x3F800000, 0x40000000, 0x40400000(last) -> out_data 0x40C00000, out_count 3, out_err 0; exactly two add_start pulses.
- Single word 0x40490FDB with last -> out_data 0x40490FDB, count 1, zero add_start pulses, out_valid 1 cycle after accept.
- 0x00000000, 0x3F800000(last) -> out_data 0x3F800000, no add_start; then 0xBF800000, 0x80000000(last) -> 0xBF800000, count 2.
- out_ready low 5 cycles during OUT -> out_valid/out_data/out_count stable, in_ready 0, in_valid ignored; result released on 6th cycle.
- Adder model never asserts done: 0x3F800000, 0x40000000(last) -> WAIT exits after TIMEOUT cycles; out_data 0x3F800000, count 2, out_err 1; next packet out_err 0.
- Assert reset during WAIT -> next cycle all outputs at reset values; fresh packet 0x40000000, 0x40000000(last) -> 0x40800000.
